mimo_zf_nxn_serial: RTL and testbench

//  - Parametrised NxN zero-forcing MIMO equaliser, successor to the fixed 2x2 datapath: X = H_inv * Y per subcarrier.
//  - Computes with one time-multiplexed complex MAC, so area is flat in NANT.
//  - Sits between channel-inverse generation and the demapper; valid/ready on both sides allows backpressure.

---
 rtl/mimo_zf_nxn_serial_pkg.sv | 32 +++
 rtl/mimo_zf_nxn_serial_if.sv | 27 ++
 rtl/mimo_zf_nxn_serial_cmac_step.sv | 36 +++
 rtl/mimo_zf_nxn_serial.sv | 136 +++++++++++++
 tb/tb_mimo_zf_nxn_serial.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mimo_zf_nxn_serial_pkg.sv
// Shared types and arithmetic helpers for the serial NxN zero-forcing equaliser.
// Build option: define ZF_ROUND_EN to round each product half-up before the FRAC shift.
package mimo_zf_pkg;

  typedef enum logic [1:0] {IDLE, MAC, DONE} zf_state_t;

`ifdef ZF_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  function automatic int acc_w(input int data_w, input int nant);
    return data_w + $clog2(nant) + 2;
  endfunction

  // Value added to a full-precision product before the FRAC shift
  function automatic longint rnd_const(input int frac);
    return ROUND_EN ? (longint'(1) <<< (frac - 1)) : 64'sd0;
  endfunction

  function automatic logic signed [31:0] sat_to_w(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mimo_zf_nxn_serial_if.sv
// Handshake and data bundle between channel-inverse generation, the equaliser and the demapper.
interface mimo_zf_nxn_serial_if #(
  parameter int DATA_W = 16,
  parameter int NANT   = 2
);
  logic                          in_valid;
  logic                          in_ready;
  logic [NANT*DATA_W-1:0]        y_re;
  logic [NANT*DATA_W-1:0]        y_im;
  logic [NANT*NANT*DATA_W-1:0]   h_re;
  logic [NANT*NANT*DATA_W-1:0]   h_im;
  logic                          out_valid;
  logic                          out_ready;
  logic [NANT*DATA_W-1:0]        x_re;
  logic [NANT*DATA_W-1:0]        x_im;
  logic                          sat_flag;

  modport master (
    output in_valid, y_re, y_im, h_re, h_im, out_ready,
    input  in_ready, out_valid, x_re, x_im, sat_flag
  );

  modport slave (
    input  in_valid, y_re, y_im, h_re, h_im, out_ready,
    output in_ready, out_valid, x_re, x_im, sat_flag
  );
endinterface

// File: rtl/mimo_zf_nxn_serial_cmac_step.sv
// Combinational complex multiply with FRAC shift; result wrapped to the accumulator width.
// Build option: ZF_ROUND_EN (via mimo_zf_pkg) adds half an LSB before the shift.
module cmac_step
  import mimo_zf_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC   = 11,
  parameter int ACC_W  = 19
) (
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  output logic signed [ACC_W-1:0]  p_re,
  output logic signed [ACC_W-1:0]  p_im
);
  localparam int PW = 2*DATA_W + 1;
  localparam logic signed [PW-1:0] RND = PW'(rnd_const(FRAC));

  logic signed [PW-1:0] ar, ai, br, bi;
  logic signed [PW-1:0] full_re, full_im, sh_re, sh_im;

  assign ar = PW'(a_re);
  assign ai = PW'(a_im);
  assign br = PW'(b_re);
  assign bi = PW'(b_im);

  assign full_re = ar*br - ai*bi + RND;
  assign full_im = ar*bi + ai*br + RND;

  assign sh_re = full_re >>> FRAC;
  assign sh_im = full_im >>> FRAC;

  assign p_re = ACC_W'(sh_re);
  assign p_im = ACC_W'(sh_im);
endmodule

// File: rtl/mimo_zf_nxn_serial.sv
// Serial NxN zero-forcing equaliser X = H_inv * Y using one time-multiplexed complex MAC.
// state | meaning
// IDLE  | ready for a Y/H_inv bundle
// MAC   | one H[row][col]*Y[col] product per cycle, row result saturated on the last column
// DONE  | X vector held on the outputs until taken downstream
module mimo_zf_nxn_serial
  import mimo_zf_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC   = 11,
  parameter int NANT   = 2
) (
  input logic                clk,
  input logic                rst,
  mimo_zf_nxn_serial_if.slave bus
);
  localparam int ACC_W = acc_w(DATA_W, NANT);
  localparam int CW    = (NANT > 1) ? $clog2(NANT) : 1;
  localparam logic [CW-1:0] LAST = CW'(NANT - 1);

  zf_state_t state;
  logic [CW-1:0] row, col;
  logic in_ready_q, out_valid_q, sat_q;

  logic signed [DATA_W-1:0] y_re_a [NANT];
  logic signed [DATA_W-1:0] y_im_a [NANT];
  logic signed [DATA_W-1:0] h_re_a [NANT][NANT];
  logic signed [DATA_W-1:0] h_im_a [NANT][NANT];
  logic signed [DATA_W-1:0] x_re_a [NANT];
  logic signed [DATA_W-1:0] x_im_a [NANT];

  logic signed [ACC_W-1:0] acc_re, acc_im, prod_re, prod_im, sum_re, sum_im;
  logic signed [31:0] sat_re, sat_im;
  logic clip;

  cmac_step #(.DATA_W(DATA_W), .FRAC(FRAC), .ACC_W(ACC_W)) u_cmac (
    .a_re (h_re_a[row][col]),
    .a_im (h_im_a[row][col]),
    .b_re (y_re_a[col]),
    .b_im (y_im_a[col]),
    .p_re (prod_re),
    .p_im (prod_im)
  );

  always_comb begin
    sum_re = acc_re + prod_re;
    sum_im = acc_im + prod_im;
    sat_re = sat_to_w(32'(sum_re), DATA_W);
    sat_im = sat_to_w(32'(sum_im), DATA_W);
    clip   = (sat_re != 32'(sum_re)) || (sat_im != 32'(sum_im));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      row         <= '0;
      col         <= '0;
      acc_re      <= '0;
      acc_im      <= '0;
      for (int k = 0; k < NANT; k++) begin
        y_re_a[k] <= '0;
        y_im_a[k] <= '0;
        x_re_a[k] <= '0;
        x_im_a[k] <= '0;
        for (int c = 0; c < NANT; c++) begin
          h_re_a[k][c] <= '0;
          h_im_a[k][c] <= '0;
        end
      end
    end else begin
      unique case (state)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            for (int k = 0; k < NANT; k++) begin
              y_re_a[k] <= bus.y_re[k*DATA_W +: DATA_W];
              y_im_a[k] <= bus.y_im[k*DATA_W +: DATA_W];
              for (int c = 0; c < NANT; c++) begin
                h_re_a[k][c] <= bus.h_re[(k*NANT+c)*DATA_W +: DATA_W];
                h_im_a[k][c] <= bus.h_im[(k*NANT+c)*DATA_W +: DATA_W];
              end
            end
            row        <= '0;
            col        <= '0;
            acc_re     <= '0;
            acc_im     <= '0;
            sat_q      <= 1'b0;
            in_ready_q <= 1'b0;
            state      <= MAC;
          end
        end
        MAC: begin
          if (col == LAST) begin
            x_re_a[row] <= DATA_W'(sat_re);
            x_im_a[row] <= DATA_W'(sat_im);
            if (clip) sat_q <= 1'b1;
            acc_re <= '0;
            acc_im <= '0;
            col    <= '0;
            if (row == LAST) begin
              row         <= '0;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else begin
              row <= row + CW'(1);
            end
          end else begin
            acc_re <= sum_re;
            acc_im <= sum_im;
            col    <= col + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sat_flag  = sat_q;

  for (genvar k = 0; k < NANT; k++) begin : g_xout
    assign bus.x_re[k*DATA_W +: DATA_W] = x_re_a[k];
    assign bus.x_im[k*DATA_W +: DATA_W] = x_im_a[k];
  end
endmodule

// File: tb/tb_mimo_zf_nxn_serial.sv
// Bench for the serial ZF equaliser: directed NANT=2 vectors and corner sequences, random NANT=4 against a model.
module tb_mimo_zf_nxn_serial;
  localparam int DW = 16;
  localparam int FR = 11;

`ifdef ZF_ROUND_EN
  localparam int     RND_X = 1;
  localparam longint RND_K = 1024;
`else
  localparam int     RND_X = 0;
  localparam longint RND_K = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst2, rst4;

  mimo_zf_nxn_serial_if #(.DATA_W(DW), .NANT(2)) b2();
  mimo_zf_nxn_serial_if #(.DATA_W(DW), .NANT(4)) b4();

  mimo_zf_nxn_serial #(.DATA_W(DW), .FRAC(FR), .NANT(2)) dut2 (.clk(clk), .rst(rst2), .bus(b2));
  mimo_zf_nxn_serial #(.DATA_W(DW), .FRAC(FR), .NANT(4)) dut4 (.clk(clk), .rst(rst4), .bus(b4));

  typedef struct packed {
    logic [63:0] h_re, h_im;
    logic [31:0] y_re, y_im, x_re, x_im;
    logic        sat;
  } vec_t;

  vec_t  tbl [7];
  string nm  [7];
  int n_chk = 0;
  int n_fail = 0;

  int hr [16], hi [16], yr [4], yi [4];
  logic [63:0] exp_re, exp_im;
  logic        exp_sat;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  function automatic logic [31:0] p2(input int a0, input int a1);
    return {16'(a1), 16'(a0)};
  endfunction

  function automatic logic [63:0] p4(input int a0, input int a1, input int a2, input int a3);
    return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  task automatic wait_ready(input int which);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if ((which == 2) ? b2.in_ready : b4.in_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) chk("in_ready_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_out(input int which, output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if ((which == 2) ? b2.out_valid : b4.out_valid) begin lat = i; break; end
    end
  endtask

  task automatic drive2(input vec_t v);
    b2.h_re = v.h_re; b2.h_im = v.h_im;
    b2.y_re = v.y_re; b2.y_im = v.y_im;
    b2.in_valid = 1'b1;
  endtask

  task automatic scramble2();
    b2.in_valid = 1'b0;
    b2.h_re = {$urandom, $urandom}; b2.h_im = {$urandom, $urandom};
    b2.y_re = $urandom;             b2.y_im = $urandom;
  endtask

  task automatic run2(input vec_t v, input string name);
    int lat;
    wait_ready(2);
    drive2(v);
    @(posedge clk); #1;
    scramble2();
    wait_out(2, lat);
    chk({name, "_latency"}, 64'(lat), 64'd4);
    chk({name, "_x_re"}, 64'(b2.x_re), 64'(v.x_re));
    chk({name, "_x_im"}, 64'(b2.x_im), 64'(v.x_im));
    chk({name, "_sat"},  64'(b2.sat_flag), 64'(v.sat));
    b2.out_ready = 1'b1;
    @(posedge clk); #1;
    b2.out_ready = 1'b0;
    chk({name, "_out_valid_drop"}, 64'(b2.out_valid), 64'd0);
  endtask

  task automatic model4();
    longint sr, si, pr, pi;
    exp_sat = 1'b0;
    for (int r = 0; r < 4; r++) begin
      sr = 0; si = 0;
      for (int c = 0; c < 4; c++) begin
        pr = longint'(hr[r*4+c]) * yr[c] - longint'(hi[r*4+c]) * yi[c];
        pi = longint'(hr[r*4+c]) * yi[c] + longint'(hi[r*4+c]) * yr[c];
        sr += (pr + RND_K) >>> FR;
        si += (pi + RND_K) >>> FR;
      end
      if (sr > 32767 || sr < -32768 || si > 32767 || si < -32768) exp_sat = 1'b1;
      if (sr > 32767) sr = 32767; else if (sr < -32768) sr = -32768;
      if (si > 32767) si = 32767; else if (si < -32768) si = -32768;
      exp_re[r*16 +: 16] = 16'(sr);
      exp_im[r*16 +: 16] = 16'(si);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit hs;
    tbl[0] = '{h_re: p4(2048, 0, 0, 2048), h_im: 64'h0, y_re: p2(1000, -300), y_im: p2(-500, 700),
               x_re: p2(1000, -300), x_im: p2(-500, 700), sat: 1'b0};
    tbl[1] = '{h_re: 64'h0, h_im: p4(2048, 0, 0, 0), y_re: p2(1000, 0), y_im: 32'h0,
               x_re: 32'h0, x_im: p2(1000, 0), sat: 1'b0};
    tbl[2] = '{h_re: p4(4096, 4096, 0, 0), h_im: 64'h0, y_re: p2(20000, 20000), y_im: 32'h0,
               x_re: p2(32767, 0), x_im: 32'h0, sat: 1'b1};
    tbl[3] = '{h_re: p4(4096, 4096, 0, 0), h_im: 64'h0, y_re: p2(-20000, -20000), y_im: 32'h0,
               x_re: p2(-32768, 0), x_im: 32'h0, sat: 1'b1};
    tbl[4] = '{h_re: p4(1, 0, 0, 0), h_im: 64'h0, y_re: p2(1024, 0), y_im: 32'h0,
               x_re: p2(RND_X, 0), x_im: 32'h0, sat: 1'b0};
    tbl[5] = '{h_re: p4(1024, -2048, 0, 512), h_im: p4(1024, 0, -1024, 0),
               y_re: p2(400, 100), y_im: p2(-200, 300),
               x_re: p2(200, -75), x_im: p2(-200, -125), sat: 1'b0};
    tbl[6] = tbl[0];
    nm = '{"identity", "rotation", "sat_pos", "sat_neg", "rounding", "mixed", "identity_again"};

    rst2 = 1'b1; rst4 = 1'b1;
    b2.in_valid = 1'b0; b2.out_ready = 1'b0;
    b2.h_re = '0; b2.h_im = '0; b2.y_re = '0; b2.y_im = '0;
    b4.in_valid = 1'b0; b4.out_ready = 1'b0;
    b4.h_re = '0; b4.h_im = '0; b4.y_re = '0; b4.y_im = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(b2.in_ready),  64'd0);
    chk("rst_out_valid", 64'(b2.out_valid), 64'd0);
    chk("rst_x_re",      64'(b2.x_re),      64'd0);
    chk("rst_x_im",      64'(b2.x_im),      64'd0);
    chk("rst_sat",       64'(b2.sat_flag),  64'd0);
    chk("rst4_in_ready", 64'(b4.in_ready),  64'd0);
    rst2 = 1'b0; rst4 = 1'b0;

    for (int i = 0; i < 7; i++) run2(tbl[i], nm[i]);

    // Backpressure: hold DONE with a second bundle waiting
    wait_ready(2);
    drive2(tbl[0]);
    @(posedge clk); #1;
    scramble2();
    wait_out(2, lat);
    chk("bp_latency", 64'(lat), 64'd4);
    drive2(tbl[5]);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_x_re_stable", 64'(b2.x_re), 64'(tbl[0].x_re));
      chk("bp_x_im_stable", 64'(b2.x_im), 64'(tbl[0].x_im));
      chk("bp_sat_stable",  64'(b2.sat_flag), 64'd0);
      chk("bp_in_ready",    64'(b2.in_ready), 64'd0);
      chk("bp_out_valid",   64'(b2.out_valid), 64'd1);
    end
    b2.out_ready = 1'b1;
    @(posedge clk); #1;
    b2.out_ready = 1'b0;
    chk("bp_release_in_ready",  64'(b2.in_ready),  64'd1);
    chk("bp_release_out_valid", 64'(b2.out_valid), 64'd0);
    @(posedge clk); #1;
    scramble2();
    wait_out(2, lat);
    chk("bp_second_latency", 64'(lat), 64'd4);
    chk("bp_second_x_re", 64'(b2.x_re), 64'(tbl[5].x_re));
    chk("bp_second_x_im", 64'(b2.x_im), 64'(tbl[5].x_im));
    b2.out_ready = 1'b1;
    @(posedge clk); #1;
    b2.out_ready = 1'b0;

    // Reset during the second MAC cycle; previous X is still nonzero
    wait_ready(2);
    drive2(tbl[0]);
    @(posedge clk); #1;
    scramble2();
    @(posedge clk); #3;
    rst2 = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(b2.out_valid), 64'd0);
    chk("midrst_x_re",      64'(b2.x_re),      64'd0);
    chk("midrst_x_im",      64'(b2.x_im),      64'd0);
    chk("midrst_in_ready",  64'(b2.in_ready),  64'd0);
    @(posedge clk); #1;
    rst2 = 1'b0;
    run2(tbl[5], "after_reset");

    // NANT=4 random bundles against the model
    for (int n = 0; n < 1000; n++) begin
      for (int k = 0; k < 16; k++) begin
        hr[k] = int'($urandom_range(0, 8190)) - 4095;
        hi[k] = int'($urandom_range(0, 8190)) - 4095;
      end
      for (int k = 0; k < 4; k++) begin
        yr[k] = int'($urandom_range(0, 65535)) - 32768;
        yi[k] = int'($urandom_range(0, 65535)) - 32768;
      end
      model4();
      wait_ready(4);
      for (int k = 0; k < 16; k++) begin
        b4.h_re[k*16 +: 16] = 16'(hr[k]);
        b4.h_im[k*16 +: 16] = 16'(hi[k]);
      end
      for (int k = 0; k < 4; k++) begin
        b4.y_re[k*16 +: 16] = 16'(yr[k]);
        b4.y_im[k*16 +: 16] = 16'(yi[k]);
      end
      b4.in_valid = 1'b1;
      @(posedge clk); #1;
      b4.in_valid = 1'b0;
      b4.h_re = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      b4.y_re = {$urandom, $urandom};
      wait_out(4, lat);
      chk("r4_latency", 64'(lat), 64'd16);
      chk("r4_x_re", b4.x_re, exp_re);
      chk("r4_x_im", b4.x_im, exp_im);
      chk("r4_sat",  64'(b4.sat_flag), 64'(exp_sat));
      hs = 1'b0;
      for (int i = 0; i < 40 && !hs; i++) begin
        hs = (i == 39) || ($urandom_range(0, 2) == 0);
        b4.out_ready = hs;
        @(posedge clk); #1;
        if (!hs) chk("r4_hold_x_re", b4.x_re, exp_re);
      end
      b4.out_ready = 1'b0;
      chk("r4_out_valid_drop", 64'(b4.out_valid), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
